// File: rtl/mem_access_unit.sv
// Load/store unit: word-aligned access to a synchronous data memory
// with lane enables, store replication and extended load results.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_e;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [3:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mis_q, mis_d;

  logic                  accept;
  logic                  bad_f3;
  logic                  bad_align;
  logic                  illegal;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           ext;

  assign accept = (state_q == IDLE) & req_valid;

  always_comb begin
    bad_f3 = 1'b0;
    if (req_we)
      bad_f3 = (req_funct3 != 3'b000) &&
               (req_funct3 != 3'b001) &&
               (req_funct3 != 3'b010);
    else
      bad_f3 = (req_funct3 == 3'b011) ||
               (req_funct3 == 3'b110) ||
               (req_funct3 == 3'b111);
    bad_align = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) &&
                 (req_addr[1:0] != 2'b00));
    illegal = bad_f3 | bad_align;
  end

  // Lane enables and replicated data are fixed at acceptance.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_d = DONE;
            mis_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 4'd1;
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAT) begin
          state_d = DONE;
          mis_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ext;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      if (accept) begin
        we_q    <= req_we;
        off_q   <= req_addr[1:0];
        f3_q    <= req_funct3;
        be_q    <= be_d;
        addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= wdata_d;
      end
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_en          = (state_q == ISSUE);
  assign mem_we          = mem_en ? be_q : 4'b0000;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign resp_valid      = (state_q == DONE);
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with response scoreboard,
// reset abort and back-to-back throughput at latencies 1 and 15.
module tb_mem_access_unit;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          due;
  } resp_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] addr;
    int          due;
  } mexp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        v1 = 1'b0, v15 = 1'b0;
  logic        rdy1, rv1, mis1, en1;
  logic        rdy15, rv15, mis15, en15;
  logic [31:0] rd1, rd15, ma1, ma15, mw1, mw15;
  logic [3:0]  we1, we15;
  logic [31:0] const_rd = 32'hCAFEF00D;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  resp_t rq[$];
  mexp_t mq[$];
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q = 32'h0;

  int last1 = -1, acc1 = 0, resp1 = 0;
  int last15 = -1, acc15 = 0, resp15 = 0;

  mem_access_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1),
    .resp_misaligned(mis1),
    .mem_en(en1), .mem_we(we1),
    .mem_addr(ma1), .mem_wdata(mw1),
    .mem_rdata(const_rd)
  );

  mem_access_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset),
    .req_valid(v15), .req_ready(rdy15),
    .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv15), .resp_rdata(rd15),
    .resp_misaligned(mis15),
    .mem_en(en15), .mem_we(we15),
    .mem_addr(ma15), .mem_wdata(mw15),
    .mem_rdata(const_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-lane memory; read word is held from the enable edge onward.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i])
          mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      rd_q <= mem[mem_addr[11:2]];
    end
  end
  assign mem_rdata = rd_q;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    resp_t r;
    mexp_t m;
    if (resp_valid) begin
      if (rq.size() == 0) bad("spurious_resp");
      else begin
        r = rq.pop_front();
        chk("resp_rdata", resp_rdata, r.rd);
        chk("resp_misaligned", 32'(resp_misaligned), 32'(r.mis));
        chk("resp_cycle", cyc, r.due);
      end
    end
    if (mem_en) begin
      if (mq.size() == 0) bad("spurious_mem_en");
      else begin
        m = mq.pop_front();
        chk("mem_we", 32'(mem_we), 32'(m.we));
        chk("mem_wdata", mem_wdata, m.wd);
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_en_cycle", cyc, m.due);
      end
    end
  end

  always @(negedge clk) begin
    if (v1 && rdy1) begin
      if (last1 >= 0) chk("b2b_gap_L1", cyc - last1, 4);
      last1 = cyc;
      acc1++;
    end
    if (rv1) begin
      resp1++;
      chk("b2b_rdata_L1", rd1, 32'hCAFEF00D);
    end
    if (v15 && rdy15) begin
      if (last15 >= 0) chk("b2b_gap_L15", cyc - last15, 18);
      last15 = cyc;
      acc15++;
    end
    if (rv15) begin
      resp15++;
      chk("b2b_rdata_L15", rd15, 32'hCAFEF00D);
    end
  end

  function automatic vec_t mk(input logic we, input logic [31:0] a,
                              input logic [2:0] f3, input logic [31:0] wd,
                              input logic [31:0] rd, input logic mis);
    vec_t v;
    v.we = we; v.addr = a; v.f3 = f3;
    v.wd = wd; v.exp_rd = rd; v.exp_mis = mis;
    return v;
  endfunction

  function automatic mexp_t mem_model(input vec_t v, input int due);
    mexp_t m;
    m.addr = v.addr & 32'hFFFF_FFFC;
    m.due  = due;
    m.we   = 4'b0000;
    m.wd   = 32'h0;
    if (v.we) begin
      if (v.f3 == 3'd0) begin
        m.we = 4'(1 << v.addr[1:0]);
        m.wd = {v.wd[7:0], v.wd[7:0], v.wd[7:0], v.wd[7:0]};
      end else if (v.f3 == 3'd1) begin
        m.we = v.addr[1] ? 4'b1100 : 4'b0011;
        m.wd = {v.wd[15:0], v.wd[15:0]};
      end else begin
        m.we = 4'b1111;
        m.wd = v.wd;
      end
    end
    return m;
  endfunction

  task automatic drive(input vec_t v);
    req_we = v.we; req_addr = v.addr;
    req_funct3 = v.f3; req_wdata = v.wd;
    req_valid = 1'b1;
  endtask

  task automatic do_req(input vec_t v);
    resp_t r;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    drive(v);
    r.rd  = v.exp_rd;
    r.mis = v.exp_mis;
    r.due = v.exp_mis ? cyc + 1 : cyc + 4;
    rq.push_back(r);
    if (!v.exp_mis) mq.push_back(mem_model(v, cyc + 1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rq.size() != 0 || mq.size() != 0); i++)
      @(negedge clk);
    if (rq.size() != 0 || mq.size() != 0) begin
      bad("timeout_waiting_resp");
      rq.delete();
      mq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    tbl.push_back(mk(1, 32'h100, 3'd2, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk(0, 32'h100, 3'd2, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h200, 3'd2, 32'h80FF7F01, 32'h0, 0));
    tbl.push_back(mk(0, 32'h203, 3'd0, 32'h0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 32'h203, 3'd4, 32'h0, 32'h00000080, 0));
    tbl.push_back(mk(0, 32'h202, 3'd4, 32'h0, 32'h000000FF, 0));
    tbl.push_back(mk(0, 32'h202, 3'd0, 32'h0, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(0, 32'h202, 3'd1, 32'h0, 32'hFFFF80FF, 0));
    tbl.push_back(mk(0, 32'h202, 3'd5, 32'h0, 32'h000080FF, 0));
    tbl.push_back(mk(0, 32'h200, 3'd1, 32'h0, 32'h00007F01, 0));
    tbl.push_back(mk(0, 32'h201, 3'd0, 32'h0, 32'h0000007F, 0));
    tbl.push_back(mk(1, 32'h301, 3'd0, 32'h12345678, 32'h0, 0));
    tbl.push_back(mk(1, 32'h302, 3'd1, 32'h0000ABCD, 32'h0, 0));
    tbl.push_back(mk(0, 32'h300, 3'd2, 32'h0, 32'hABCD7800, 0));
    tbl.push_back(mk(0, 32'h300, 3'd5, 32'h0, 32'h00007800, 0));
    tbl.push_back(mk(0, 32'h302, 3'd0, 32'h0, 32'hFFFFFFCD, 0));
    tbl.push_back(mk(0, 32'h302, 3'd1, 32'h0, 32'hFFFFABCD, 0));
    tbl.push_back(mk(0, 32'h101, 3'd2, 32'h0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h303, 3'd1, 32'h5555, 32'h0, 1));
    tbl.push_back(mk(0, 32'h100, 3'd3, 32'h0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h100, 3'd4, 32'h1, 32'h0, 1));
    tbl.push_back(mk(0, 32'h201, 3'd1, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 32'h202, 3'd2, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 32'h200, 3'd6, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 32'h200, 3'd7, 32'h0, 32'h0, 1));

    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_mis", 32'(resp_misaligned), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      do_req(tbl[i]);
      drain();
    end

    // Abort a load during WAIT; its memory strobe still happens first.
    v = mk(0, 32'h100, 3'd2, 32'h0, 32'h0, 0);
    @(negedge clk);
    drive(v);
    mq.push_back(mem_model(v, cyc + 1));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_no_pending", mq.size(), 0);
    do_req(mk(0, 32'h100, 3'd2, 32'h0, 32'hDEADBEEF, 0));
    drain();

    // Back-to-back loads with request held high.
    req_we = 1'b0; req_addr = 32'h40; req_funct3 = 3'd2;
    @(posedge clk);
    #1 v1 = 1'b1;
    repeat (40) @(posedge clk);
    #1 v1 = 1'b0;
    repeat (10) @(posedge clk);
    chk("b2b_acc_L1", acc1, 10);
    chk("b2b_resp_L1", resp1, acc1);

    @(posedge clk);
    #1 v15 = 1'b1;
    repeat (90) @(posedge clk);
    #1 v15 = 1'b0;
    repeat (25) @(posedge clk);
    chk("b2b_acc_L15", acc15, 5);
    chk("b2b_resp_L15", resp15, acc15);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
